// File: rtl/apb_mem_slave_p_pkg.sv
// apb_pkg: shared definitions for the APB4 memory slave.
//   apb_state_t  - slave FSM states
//   RESP_*       - pslverr response encodings
//   clog2w()     - index width helper (never returns less than 1)
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_mem_slave_p_if.sv
// apb_mem_slave_p_if: APB4 completer-side bus bundle.
//   master modport drives psel/penable/pwrite/paddr/pprot/pwdata/pstrb,
//   slave modport drives prdata/pready/pslverr.
interface apb_mem_slave_p_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   modport master (output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/apb_mem_slave_p_ram.sv
// apb_byte_ram: DEPTH x DATA_WIDTH storage, byte-strobed synchronous write,
// combinational read, whole array cleared by async reset.
//   clk, rst          clock / async active-high clear
//   i_we, i_strb      write enable and per-byte enables
//   i_addr            word index (shared by read and write)
//   i_wdata, o_rdata  write data / combinational read data
module apb_byte_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_we,
   input  logic [$clog2(DEPTH)-1:0]  i_addr,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_strb,
   output logic [DATA_WIDTH-1:0]     o_rdata
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++)
            if (i_strb[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
   end

   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: parameterised APB4 memory slave with programmable wait
// states, address-decode error response and a saturating error counter.
//   pclk, preset   clock / async active-high reset
//   bus (slave)    APB4 signals, see apb_mem_slave_p_if
//   err_cnt        number of pslverr responses, saturates at all-ones
// Optional: define APB_MEM_SLAVE_PROT_EN to enable pprot-based access errors
// (unprivileged writes, non-secure reads of word 0).
module apb_mem_slave_p
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 32,
   parameter int WAIT_STATES   = 0,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     pclk,
   input  logic                     preset,
   apb_mem_slave_p_if.slave         bus,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
   localparam int LSB  = $clog2(DATA_WIDTH/8);
   localparam int IDXW = clog2w(DEPTH);

   apb_state_t             r_state;
   logic [3:0]             r_wait;
   logic [DATA_WIDTH-1:0]  r_prdata;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

   logic [IDXW-1:0]        w_idx;
   logic [DATA_WIDTH-1:0]  w_rdata;
   logic w_misalign, w_oor, w_prot_err, w_err;
   logic w_setup, w_acc, w_viol, w_done, w_we, w_pready, w_pslverr;

   // ---- address decode ----
   assign w_idx = bus.paddr[LSB +: IDXW];
   assign w_oor = (bus.paddr >> (LSB + IDXW)) != '0;

   if (LSB > 0) begin : g_align
      assign w_misalign = |bus.paddr[LSB-1:0];
   end else begin : g_noalign
      assign w_misalign = 1'b0;
   end

`ifdef APB_MEM_SLAVE_PROT_EN
   assign w_prot_err = bus.pwrite ? ~bus.pprot[0]
                                  : (bus.pprot[1] & (w_idx == '0));
`else
   logic w_unused_prot;
   assign w_unused_prot = ^bus.pprot;
   assign w_prot_err    = 1'b0;
`endif

   assign w_err = w_misalign | w_oor | w_prot_err;

   // ---- phase decode ----
   // SETUP marks the first access cycle after a captured setup phase;
   // ACCESS marks the wait-extended ones. Either way the FSM is "busy".
   assign w_setup = bus.psel & ~bus.penable;
   assign w_acc   = (r_state != IDLE) & bus.psel & bus.penable;
   // An access phase that was never preceded by a setup phase.
   assign w_viol  = (r_state == IDLE) & bus.psel & bus.penable;
   assign w_done  = w_acc & (r_wait == '0);
   assign w_we    = w_done & bus.pwrite & ~w_err;

   assign w_pready  = ~preset & (w_done | w_viol);
   assign w_pslverr = ~preset & ((w_done & w_err) | w_viol) ? RESP_SLVERR : RESP_OKAY;

   assign bus.pready  = w_pready;
   assign bus.pslverr = w_pslverr;
   assign bus.prdata  = r_prdata;
   assign err_cnt     = r_err_cnt;

   apb_byte_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk     (pclk),
      .rst     (preset),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (bus.pwdata),
      .i_strb  (bus.pstrb),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state   <= IDLE;
         r_wait    <= '0;
         r_prdata  <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_pready && w_pslverr && !(&r_err_cnt))
            r_err_cnt <= r_err_cnt + 1'b1;

         case (r_state)
            SETUP, ACCESS: begin
               if (!bus.psel)
                  r_state <= IDLE;               // abort: nothing written
               else if (bus.penable) begin
                  if (r_wait == '0)
                     r_state <= IDLE;            // completion
                  else begin
                     r_state <= ACCESS;
                     r_wait  <= r_wait - 1'b1;
                  end
               end else
                  r_state <= SETUP;              // fresh setup phase
            end
            default: if (w_setup) r_state <= SETUP;
         endcase

         // Read data is fetched at the setup edge so it is already valid
         // in the first access cycle, regardless of wait states.
         if (w_setup) begin
            r_wait <= 4'(WAIT_STATES);
            if (!bus.pwrite) r_prdata <= w_err ? '0 : w_rdata;
         end
      end
   end
endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
Parametrised APB4 memory slave. It is the next generation of the team's fixed 32x32 storage slave, and replaces the combinational-write storage with a clocked, byte-strobed RAM. It adds a programmable wait-state insertion counter, address decode with error response, and an error counter. It sits behind the APB master/decoder; one instance is used per psel line.

Parameters:
ADDR_WIDTH, 32, width of paddr (byte address)
DATA_WIDTH, 32, data bus width; legal values are 8, 16 and 32
DEPTH, 32, number of DATA_WIDTH words; must be a power of two, at least 2
WAIT_STATES, 0, wait cycles inserted before pready in every access phase, range 0..15
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
pclk  in  1  APB clock; all state changes on its rising edge
preset  in  1  asynchronous active-high reset
psel  in  1  slave select
penable  in  1  access-phase indicator
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  byte address
pprot  in  3  protection attributes; used only with the optional feature
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  byte write strobes
prdata  out  DATA_WIDTH  read data, registered
pready  out  1  transfer-complete indicator
pslverr  out  1  error response; qualified by pready
err_cnt  out  ERR_CNT_WIDTH  count of error responses, saturating

Behaviour:
- Reset (preset=1, async): state=IDLE, wait_cnt=0, prdata=0, err_cnt=0, all RAM words=0. pready=0 and pslverr=0 while in reset.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); word index = paddr[LSB +: log2(DEPTH)].
  - Misaligned: paddr[LSB-1:0] != 0 (not applicable when DATA_WIDTH=8).
  - Out of range: any paddr bit at position LSB+log2(DEPTH) or above is 1.
  - err_addr = misaligned OR out of range.
- State machine (IDLE, SETUP, ACCESS):
  - IDLE -> SETUP on psel & ~penable.
  - SETUP -> ACCESS unconditionally.
  - ACCESS with pready=1: -> SETUP if psel & ~penable, else -> IDLE.
  - ACCESS with pready=0: stay in ACCESS.
- Setup edge (psel & ~penable, state IDLE or ACCESS-completing):
  - wait_cnt <= WAIT_STATES.
  - If read and ~err_addr: prdata <= RAM[index]. If read and err_addr: prdata <= 0.
- Access phase (state=ACCESS, psel & penable):
  - pready = (wait_cnt==0), combinational.
  - wait_cnt decrements each cycle while nonzero.
  - Latency: access phase lasts WAIT_STATES+1 cycles; total transfer is WAIT_STATES+2 cycles.
- Completion edge (ACCESS & pready):
  - Write with ~err: RAM bytes with pstrb[i]=1 updated from pwdata; other bytes unchanged.
  - pstrb=0 write: no RAM change, pslverr=0.
  - pslverr = err_addr during the completing cycle; 0 at all other times.
  - err_cnt increments on each completion with pslverr=1 and saturates at all-ones.
- Errored write: RAM is never modified.
- prdata is held between transfers and is not updated by writes.
- Protocol violation: psel & penable seen in IDLE or SETUP-less entry:
  - Respond pready=1, pslverr=1 in that same cycle.
  - No RAM write; err_cnt increments; state -> IDLE.
- psel dropped mid-access (before pready): abort the transfer, state -> IDLE, no write, no err_cnt change.
- Reset asserted mid-transfer: immediate return to reset values; a pending write is discarded.
- Back-to-back transfers (no IDLE between them) are supported at full rate.

Optional Feature:
Macro APB_MEM_SLAVE_PROT_EN.
- Defined:
  - A write with pprot[0]=0 (unprivileged) → error: pslverr=1, no RAM change, err_cnt increments.
  - A read with pprot[1]=1 (non-secure) and word index 0 → error: prdata=0, pslverr=1.
- Undefined: pprot is ignored; no protection errors are generated.

Decomposition:
Shared package apb_pkg holds:
- state enum with values IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2;
- response constants RESP_OKAY=1'b0 and RESP_SLVERR=1'b1;
- the clog2-derived width helper.

One sub-module, apb_byte_ram (DATA_WIDTH, DEPTH):
- synchronous write with byte enables;
- combinational read;
- async-clear on preset.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x08 with pstrb=4'hF, then read 0x08 → prdata=0xDEADBEEF, pslverr=0; each transfer takes 2 cycles with WAIT_STATES=0.
- Write 0x11223344 to 0x04, then write 0xAABBCCDD with pstrb=4'b0101, then read 0x04 → 0x11BB33DD.
- WAIT_STATES=3: read 0x08 → pready low for 3 access cycles, high on the 4th; prdata is already valid at the first access cycle.
- Write to 0x80 (DEPTH=32, out of range) and read from 0x02 (misaligned) → pslverr=1 on each completion, RAM unchanged, prdata=0 for the read, err_cnt=2.
- Back-to-back write 0x0C / read 0x0C with no IDLE between them → read returns the new data; assert preset during the access phase of a write to 0x10 → a later read of 0x10 returns 0, and err_cnt=0.
- With APB_MEM_SLAVE_PROT_EN: write pprot=3'b000 to 0x00 → pslverr=1 and data unchanged; repeat with pprot=3'b001 → pslverr=0.
